// File: rtl/farm_sensor_conditioner.sv
// Farm-road detector conditioner: sync + debounce of raw_sensor, held request
// FSM toward the traffic controller with post-green hold-off, saturating arrival count.
module farm_sensor_conditioner #(
  parameter int TICK_DIV       = 4,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int HOLDOFF_TICKS  = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_sensor,
  input  logic [1:0]       farm_signal,
  output logic             sensor,
  output logic             stable_present,
  output logic [CNT_W-1:0] car_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLDOFF_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_SERVING = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  logic [PW-1:0]    prescaler_q, prescaler_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             stable_q, stable_d;
  logic             pending_q, pending_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             tick;
  logic             arrival;

  always_comb begin
    tick        = (prescaler_q == PW'(TICK_DIV - 1));
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    sync1_d     = raw_sensor;
    sync2_d     = sync1_q;

    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
        stable_d = ~stable_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Arrival is seen in the same cycle the debounced level is updated, so the
    // request and the count land on the same edge as stable_present.
    arrival = stable_d & ~stable_q;
    count_d = (arrival && (count_q != {CNT_W{1'b1}})) ? count_q + 1'b1 : count_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pending_d  = pending_q;

    if (arrival && (state_q == S_SERVING || state_q == S_HOLDOFF)) begin
      pending_d = 1'b1;
    end

    if (farm_signal != 2'b00) begin
      case (state_q)
        S_IDLE: begin
          if (arrival) state_d = S_REQUEST;
        end
        S_REQUEST: begin
          if (farm_signal == 2'b01) state_d = S_SERVING;
        end
        S_SERVING: begin
          if (farm_signal == 2'b11) begin
            state_d    = S_HOLDOFF;
            hold_cnt_d = '0;
          end
        end
        S_HOLDOFF: begin
          if (tick) begin
            if (hold_cnt_q == HW'(HOLDOFF_TICKS - 1)) begin
              hold_cnt_d = '0;
              state_d    = (pending_q || stable_q || arrival) ? S_REQUEST : S_IDLE;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The request being raised consumes any arrival remembered during service.
    if (state_d == S_REQUEST && state_q != S_REQUEST) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      stable_q    <= 1'b0;
      pending_q   <= 1'b0;
      hold_cnt_q  <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
    end else begin
      prescaler_q <= prescaler_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      stable_q    <= stable_d;
      pending_q   <= pending_d;
      hold_cnt_q  <= hold_cnt_d;
      count_q     <= count_d;
      state_q     <= state_d;
    end
  end

  assign sensor         = (state_q == S_REQUEST);
  assign stable_present = stable_q;
  assign car_count      = count_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed bench for farm_sensor_conditioner: reset, debounce latency, service
// cycle, glitch rejection, pending re-request, mid-run reset and count saturation.
module tb_farm_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_sensor;
  logic [1:0] farm_signal;
  logic       sensor;
  logic       stable_present;
  logic [7:0] car_count;

  int test_cnt = 0;
  int fail_cnt = 0;

  farm_sensor_conditioner #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLDOFF_TICKS(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .raw_sensor(raw_sensor), .farm_signal(farm_signal),
    .sensor(sensor), .stable_present(stable_present), .car_count(car_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges counted until sensor is seen high; -1 when it never rises within max_n.
  task automatic measure_sensor(input int max_n, output int n);
    n = -1;
    for (int i = 1; i <= max_n; i++) begin
      step(1);
      if (sensor === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; raw_sensor = 1'b0; farm_signal = 2'b11;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      test_cnt++;
      if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL reset_sensor cyc %0d: got %b expected 0", i, sensor); end
      test_cnt++;
      if (stable_present !== 1'b0) begin fail_cnt++; $display("FAIL reset_stable cyc %0d: got %b expected 0", i, stable_present); end
      test_cnt++;
      if (car_count !== 8'd0) begin fail_cnt++; $display("FAIL reset_count cyc %0d: got %0d expected 0", i, car_count); end
    end
  endtask

  task automatic test_arrival();
    int n;
    raw_sensor = 1'b1;
    measure_sensor(30, n);
    test_cnt++;
    if (n < 11 || n > 14) begin fail_cnt++; $display("FAIL arrival_latency: got %0d expected 11..14", n); end
    test_cnt++;
    if (car_count !== 8'd1) begin fail_cnt++; $display("FAIL arrival_count: got %0d expected 1", car_count); end
    test_cnt++;
    if (stable_present !== 1'b1) begin fail_cnt++; $display("FAIL arrival_stable: got %b expected 1", stable_present); end
    farm_signal = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step(1);
      test_cnt++;
      if (sensor !== 1'b1) begin fail_cnt++; $display("FAIL request_hold cyc %0d: got %b expected 1", i, sensor); end
    end
  endtask

  task automatic test_serve();
    farm_signal = 2'b01;
    raw_sensor  = 1'b0;
    step(1);
    test_cnt++;
    if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL serve_grant: got %b expected 0", sensor); end
    farm_signal = 2'b10;
    step(12);
    test_cnt++;
    if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL serve_yellow: got %b expected 0", sensor); end
    farm_signal = 2'b11;
    for (int i = 0; i < 25; i++) begin
      step(1);
      test_cnt++;
      if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL holdoff_idle cyc %0d: got %b expected 0", i, sensor); end
    end
    test_cnt++;
    if (stable_present !== 1'b0) begin fail_cnt++; $display("FAIL serve_stable: got %b expected 0", stable_present); end
    test_cnt++;
    if (car_count !== 8'd1) begin fail_cnt++; $display("FAIL serve_count: got %0d expected 1", car_count); end
  endtask

  task automatic test_glitch();
    for (int p = 0; p < 5; p++) begin
      raw_sensor = 1'b1;
      for (int i = 0; i < 26; i++) begin
        if (i == 6) raw_sensor = 1'b0;
        step(1);
        test_cnt++;
        if (stable_present !== 1'b0 || sensor !== 1'b0) begin
          fail_cnt++;
          $display("FAIL glitch p%0d cyc %0d: got stable=%b sensor=%b expected 0/0", p, i, stable_present, sensor);
        end
      end
    end
    test_cnt++;
    if (car_count !== 8'd1) begin fail_cnt++; $display("FAIL glitch_count: got %0d expected 1", car_count); end
  endtask

  task automatic test_pending();
    int n;
    raw_sensor = 1'b1;
    measure_sensor(30, n);
    test_cnt++;
    if (n < 11 || n > 14) begin fail_cnt++; $display("FAIL pend_latency: got %0d expected 11..14", n); end
    test_cnt++;
    if (car_count !== 8'd2) begin fail_cnt++; $display("FAIL pend_count1: got %0d expected 2", car_count); end
    farm_signal = 2'b01;
    step(1);
    raw_sensor = 1'b0;
    step(20);
    test_cnt++;
    if (stable_present !== 1'b0) begin fail_cnt++; $display("FAIL pend_drop: got %b expected 0", stable_present); end
    raw_sensor = 1'b1;
    step(16);
    test_cnt++;
    if (car_count !== 8'd3) begin fail_cnt++; $display("FAIL pend_count2: got %0d expected 3", car_count); end
    test_cnt++;
    if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL pend_serving: got %b expected 0", sensor); end
    raw_sensor = 1'b0;
    step(20);
    test_cnt++;
    if (stable_present !== 1'b0) begin fail_cnt++; $display("FAIL pend_drop2: got %b expected 0", stable_present); end
    farm_signal = 2'b11;
    step(1);
    test_cnt++;
    if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL pend_holdoff: got %b expected 0", sensor); end
    measure_sensor(12, n);
    test_cnt++;
    if (n < 1 || n > 8) begin fail_cnt++; $display("FAIL pend_rerequest: got %0d expected 1..8", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    raw_sensor = 1'b1;
    step(20);
    test_cnt++;
    if (car_count !== 8'd4) begin fail_cnt++; $display("FAIL mid_count_pre: got %0d expected 4", car_count); end
    test_cnt++;
    if (sensor !== 1'b1) begin fail_cnt++; $display("FAIL mid_sensor_pre: got %b expected 1", sensor); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    test_cnt++;
    if (sensor !== 1'b0) begin fail_cnt++; $display("FAIL mid_sensor: got %b expected 0", sensor); end
    test_cnt++;
    if (car_count !== 8'd0) begin fail_cnt++; $display("FAIL mid_count: got %0d expected 0", car_count); end
    test_cnt++;
    if (stable_present !== 1'b0) begin fail_cnt++; $display("FAIL mid_stable: got %b expected 0", stable_present); end
    measure_sensor(30, n);
    test_cnt++;
    if (n < 11 || n > 14) begin fail_cnt++; $display("FAIL mid_latency: got %0d expected 11..14", n); end
    test_cnt++;
    if (car_count !== 8'd1) begin fail_cnt++; $display("FAIL mid_count_post: got %0d expected 1", car_count); end
  endtask

  task automatic test_saturation();
    raw_sensor = 1'b0;
    step(16);
    for (int a = 1; a <= 260; a++) begin
      raw_sensor = 1'b1;
      step(16);
      raw_sensor = 1'b0;
      step(16);
      if (a == 10) begin
        test_cnt++;
        if (car_count !== 8'd11) begin fail_cnt++; $display("FAIL sat_count10: got %0d expected 11", car_count); end
      end
      if (a == 254) begin
        test_cnt++;
        if (car_count !== 8'd255) begin fail_cnt++; $display("FAIL sat_reach: got %0d expected 255", car_count); end
      end
    end
    test_cnt++;
    if (car_count !== 8'd255) begin fail_cnt++; $display("FAIL sat_hold: got %0d expected 255", car_count); end
  endtask

  initial begin
    rst = 1'b1; raw_sensor = 1'b0; farm_signal = 2'b11;
    test_reset();
    test_arrival();
    test_serve();
    test_glitch();
    test_pending();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
